// File: rtl/cancid_regex_ctx_mgr.sv
// Per-stream DFA context manager: restores/saves DFA state and counts matching packets per stream.
// Optional CANCID_CTX_SAT_EN: per-stream match counters saturate instead of wrapping.
module cancid_regex_ctx_mgr #(
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int STATE_W     = 11,
  parameter int COUNT_W     = 16,
  parameter int DFA_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sop,
  input  logic [SID_W-1:0]   sop_stream_id,
  input  logic               enable,
  output logic               ctx_ready,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               flush,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept,
  input  logic [SID_W-1:0]   rd_stream_id,
  output logic [COUNT_W-1:0] rd_count,
  output logic               pkt_done,
  output logic               pkt_fired
);
  localparam int DRAIN_W = $clog2(DFA_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DFA_LAT);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, SAVE} state_t;
  state_t state_reg, state_next;

  logic [SID_W-1:0]   sid_reg;
  logic               enable_reg;
  logic               fired_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [STATE_W-1:0] state_mem [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid_vec;
  logic [COUNT_W-1:0] count_arr [NUM_STREAMS];
  logic               commit;
  logic               commit_en;

  assign commit    = (state_reg == SAVE);
  assign commit_en = commit && enable_reg;
  assign ctx_ready = (state_reg == IDLE);
  assign pkt_done  = commit;
  assign pkt_fired = commit_en && fired_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sop) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (char_in_vld && eop) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == DRAIN_LAST) state_next = SAVE;
      SAVE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain holds off commit until the accept for the last forwarded byte has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sid_reg          <= '0;
      enable_reg       <= 1'b0;
      fired_reg        <= 1'b0;
      drain_cnt_reg    <= '0;
      dfa_char         <= '0;
      dfa_char_vld     <= 1'b0;
      dfa_state_in     <= '0;
      dfa_state_in_vld <= 1'b0;
    end else begin
      if (state_reg == IDLE && sop) begin
        sid_reg    <= sop_stream_id;
        enable_reg <= enable;
        fired_reg  <= 1'b0;
      end else if ((state_reg == RUN || state_reg == DRAIN) && dfa_accept) begin
        fired_reg <= 1'b1;
      end
      if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
      else                    drain_cnt_reg <= '0;
      dfa_char_vld <= (state_reg == RUN) && char_in_vld;
      if (state_reg == RUN && char_in_vld) dfa_char <= char_in;
      dfa_state_in_vld <= (state_reg == LOAD);
      if (state_reg == LOAD)
        dfa_state_in <= valid_vec[sid_reg] ? state_mem[sid_reg] : '0;
    end
  end

  // State memory is not reset; valid bits guard stale contents.
  always_ff @(posedge clk) begin
    if (commit_en) state_mem[sid_reg] <= dfa_state_out;
  end

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
    logic               hit;
    logic               valid_q;
    logic [COUNT_W-1:0] count_q;

    assign hit           = commit_en && (sid_reg == SID_W'(gi));
    assign valid_vec[gi] = valid_q;
    assign count_arr[gi] = count_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        count_q <= '0;
      end else begin
        if (flush)    valid_q <= 1'b0;
        else if (hit) valid_q <= 1'b1;
        if (hit && fired_reg) begin
`ifdef CANCID_CTX_SAT_EN
          if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + COUNT_W'(1);
`else
          count_q <= count_q + COUNT_W'(1);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_count <= '0;
    else     rd_count <= count_arr[rd_stream_id];
  end
endmodule

// File: doc/cancid_regex_ctx_mgr.md
Name: cancid_regex_ctx_mgr

Overview:
- Parametrised per-stream context manager for one regex DFA engine in the kraaken DPI datapath.
- Successor to the single-category save/restore wrapper: NUM_STREAMS-deep state memory, internal new-stream tracking, per-stream match counters with a read port, explicit packet handshake and pipeline drain before commit.
- DFA engine is external; its ports connect through this block's registered dfa_* interface.

Parameters:
- NUM_STREAMS, 64, number of stream contexts; power of 2.
- SID_W, 6, stream id width; equals log2(NUM_STREAMS).
- STATE_W, 11, DFA state width.
- COUNT_W, 16, per-stream match counter width.
- DFA_LAT, 1, cycles from dfa_char_vld to the matching dfa_accept/dfa_state_out.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- sop  in  1  packet start; sampled only when ctx_ready=1.
- sop_stream_id  in  SID_W  stream of the packet starting.
- enable  in  1  regex enabled for this packet; sampled with sop.
- ctx_ready  out  1  high in IDLE only.
- char_in  in  8  payload byte.
- char_in_vld  in  1  byte valid; honoured only in RUN.
- eop  in  1  last byte marker; qualified by char_in_vld in RUN.
- flush  in  1  invalidates all stream contexts.
- dfa_char  out  8  registered byte to DFA.
- dfa_char_vld  out  1  registered.
- dfa_state_in  out  STATE_W  restored state.
- dfa_state_in_vld  out  1  one-cycle load pulse.
- dfa_state_out  in  STATE_W  DFA current state.
- dfa_accept  in  1  DFA match.
- rd_stream_id  in  SID_W  count read address.
- rd_count  out  COUNT_W  count of rd_stream_id, 1-cycle latency.
- pkt_done  out  1  one-cycle pulse at commit.
- pkt_fired  out  1  match flag of committed packet, valid with pkt_done.

Behaviour:
- Reset: FSM=IDLE; all valid bits, all counters, all outputs 0; ctx_ready=1 after reset release. State memory not reset (guarded by valid bits).
- FSM IDLE→LOAD on sop: latch sop_stream_id, enable; clear fired flag.
- LOAD (1 cycle): dfa_state_in = state_mem[sid] if valid[sid] else 0; dfa_state_in_vld=1 next cycle; →RUN.
- RUN: each char_in_vld registers to dfa_char/dfa_char_vld (1 cycle). char_in_vld with eop → DRAIN.
- DRAIN: waits DFA_LAT+1 cycles so the accept of the last byte is seen; →SAVE.
- fired flag: set by dfa_accept in RUN or DRAIN; sticky until the next LOAD.
- SAVE (1 cycle): if enable: state_mem[sid]<=dfa_state_out, valid[sid]<=1, count[sid]<=count[sid]+fired. If enable=0: no memory, valid or count change. pkt_done=1; pkt_fired=fired&enable; →IDLE.
- Counter wrap: modulo 2^COUNT_W unless CANCID_CTX_SAT_EN.
- rd_count: registered read; a read of sid in the SAVE cycle returns the pre-update value.
- flush: clears all valid bits in one cycle in any state. If asserted during SAVE, flush wins for valid[sid]; the state write still occurs.
- sop when ctx_ready=0: ignored. char_in_vld outside RUN: ignored, never forwarded.
- Async reset mid-packet: immediate return to IDLE; packet discarded; counts cleared.

Optional Feature:
- CANCID_CTX_SAT_EN defined: per-stream counters saturate at 2^COUNT_W-1.
- Undefined: counters wrap to 0.

Test Plan:
- Fresh stream: sop sid=5, enable=1, bytes with dfa_accept on byte 3 → dfa_state_in=0; pkt_fired=1; rd_count(5)=1.
- Resume: second packet on sid=5 → dfa_state_in equals the state saved at the first SAVE; no accept → count stays 1, pkt_fired=0.
- Disabled: enable=0, accept asserted → pkt_fired=0; count(5) unchanged; state_mem[5] unchanged on the next load.
- Late accept: accept only on the eop byte, DFA_LAT=1 → captured in DRAIN; count increments.
- flush between packets on sid=5 → next load presents state 0. Then a sop while busy → ignored; ctx_ready=0 throughout.
- Counter boundary: preload count(7)=0xFFFF, firing packet → 0x0000 without macro; 0xFFFF with CANCID_CTX_SAT_EN.
